// File: rtl/if_mchan_bridge.sv
// Multi-channel en/rdy slave bridge: per-channel FIFOs drained round-robin
// into a single valid/ack output stage.

module if_mchan_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      level,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [AW:0]      lvl_nxt;

    always_comb begin
        lvl_nxt = level;
        if (push && !pop)
            lvl_nxt = level + (AW+1)'(1);
        else if (pop && !push)
            lvl_nxt = level - (AW+1)'(1);
    end

    always_ff @(posedge ck) begin
        if (push)
            mem[wp] <= wdata;
    end

    // Flags are registered from the next level so they never lag it.
    always_ff @(posedge ck) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop)  rp <= rp + AW'(1);
            level <= lvl_nxt;
            full  <= (lvl_nxt == (AW+1)'(DEPTH));
            empty <= (lvl_nxt == '0);
        end
    end

    assign rdata = mem[rp];
endmodule

module if_mchan_bridge #(
    parameter int WIDTH        = 16,
    parameter int NCH          = 4,
    parameter int DEPTH        = 8,
    parameter int DROP_ON_FULL = 0,
    localparam int CHW = $clog2(NCH),
    localparam int AW  = $clog2(DEPTH)
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      sync_txd,
    input  logic [CHW-1:0]        sync_txch,
    input  logic                  async_en,
    output logic                  async_rdy,
    output logic [WIDTH-1:0]      sync_rxd,
    output logic [CHW-1:0]        sync_rxch,
    output logic                  rx_vld,
    input  logic                  rx_ack,
    output logic [NCH-1:0]        ch_full,
    output logic [NCH-1:0]        ch_empty,
    output logic [NCH*(AW+1)-1:0] ch_level,
    output logic [15:0]           drop_cnt
);
    localparam logic [CHW:0] NCH_V = (CHW+1)'(NCH);

    logic [NCH-1:0][WIDTH-1:0] head;
    logic [NCH-1:0][AW:0]      lvl_arr;
    logic [NCH-1:0]            push_v, pop_v;
    logic                      id_ok, tgt_full, push_ok, drop, load, found;
    logic [CHW-1:0]            gnt, rr_ptr;

    assign id_ok    = {1'b0, sync_txch} < NCH_V;
    assign tgt_full = id_ok ? ch_full[sync_txch] : 1'b1;
    assign push_ok  = async_en && async_rdy && id_ok && !tgt_full;
    assign drop     = (DROP_ON_FULL != 0) && async_en && !rst && (!id_ok || tgt_full);
    assign load     = !rx_vld || rx_ack;
    assign ch_level = lvl_arr;

    // Ready depends only on registered flags, never on a same-cycle pop.
    if (DROP_ON_FULL != 0) begin : g_drop
        assign async_rdy = !rst;
    end else begin : g_bp
        assign async_rdy = id_ok && !tgt_full;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign push_v[i] = push_ok && (sync_txch == CHW'(i));
        assign pop_v[i]  = load && found && (gnt == CHW'(i));

        if_mchan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_fifo (
            .ck    (ck),
            .rst   (rst),
            .push  (push_v[i]),
            .wdata (sync_txd),
            .pop   (pop_v[i]),
            .rdata (head[i]),
            .level (lvl_arr[i]),
            .full  (ch_full[i]),
            .empty (ch_empty[i])
        );
    end

    // First non-empty channel strictly after the last grant, wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        gnt   = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(rr_ptr) + k) % NCH;
            if (!found && !ch_empty[CHW'(idx)]) begin
                found = 1'b1;
                gnt   = CHW'(idx);
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            rx_vld    <= 1'b0;
            sync_rxd  <= '0;
            sync_rxch <= '0;
            rr_ptr    <= CHW'(NCH - 1);
            drop_cnt  <= '0;
        end else begin
            if (load) begin
                if (found) begin
                    sync_rxd  <= head[gnt];
                    sync_rxch <= gnt;
                    rx_vld    <= 1'b1;
                    rr_ptr    <= gnt;
                end else begin
                    rx_vld <= 1'b0;
                end
            end
            if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_if_mchan_bridge.sv
// Directed bench: back-pressure bridge (NCH=4) and drop-mode bridge (NCH=5).

module tb_if_mchan_bridge;
    logic        ck = 1'b0;
    logic        rst;
    int          checks = 0;
    int          errors = 0;

    // back-pressure instance
    logic [15:0] a_txd, a_rxd;
    logic [1:0]  a_txch, a_rxch;
    logic        a_en, a_rdy, a_vld, a_ack;
    logic [3:0]  a_full, a_empty;
    logic [15:0] a_level;
    logic [15:0] a_drop;

    // drop-mode instance
    logic [15:0] b_txd, b_rxd;
    logic [2:0]  b_txch, b_rxch;
    logic        b_en, b_rdy, b_vld, b_ack;
    logic [4:0]  b_full, b_empty;
    logic [19:0] b_level;
    logic [15:0] b_drop;

    always #5 ck = ~ck;

    if_mchan_bridge #(.WIDTH(16), .NCH(4), .DEPTH(8), .DROP_ON_FULL(0)) dut_a (
        .ck(ck), .rst(rst), .sync_txd(a_txd), .sync_txch(a_txch), .async_en(a_en),
        .async_rdy(a_rdy), .sync_rxd(a_rxd), .sync_rxch(a_rxch), .rx_vld(a_vld),
        .rx_ack(a_ack), .ch_full(a_full), .ch_empty(a_empty), .ch_level(a_level),
        .drop_cnt(a_drop)
    );

    if_mchan_bridge #(.WIDTH(16), .NCH(5), .DEPTH(8), .DROP_ON_FULL(1)) dut_b (
        .ck(ck), .rst(rst), .sync_txd(b_txd), .sync_txch(b_txch), .async_en(b_en),
        .async_rdy(b_rdy), .sync_rxd(b_rxd), .sync_rxch(b_rxch), .rx_vld(b_vld),
        .rx_ack(b_ack), .ch_full(b_full), .ch_empty(b_empty), .ch_level(b_level),
        .drop_cnt(b_drop)
    );

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic write_a(input logic [1:0] ch, input logic [15:0] d);
        a_txch = ch; a_txd = d; a_en = 1'b1;
        tick();
        a_en = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (a_empty !== 4'hF) begin errors++; $display("FAIL rst_empty: got %h expected f", a_empty); end
        checks++; if (a_full !== 4'h0) begin errors++; $display("FAIL rst_full: got %h expected 0", a_full); end
        checks++; if (a_level !== 16'h0) begin errors++; $display("FAIL rst_level: got %h expected 0", a_level); end
        checks++; if ({a_vld, a_rxd, a_rxch} !== 19'h0) begin errors++; $display("FAIL rst_out: vld %b rxd %h rxch %0d expected all 0", a_vld, a_rxd, a_rxch); end
        checks++; if (b_rdy !== 1'b1) begin errors++; $display("FAIL b_rdy_run: got %b expected 1", b_rdy); end
        // three words into ch1, one already in the output stage, then reset
        a_ack = 1'b0;
        write_a(2'd1, 16'h1111);
        write_a(2'd1, 16'h1112);
        write_a(2'd1, 16'h1113);
        checks++; if (a_level[7:4] !== 4'd2 || a_vld !== 1'b1) begin errors++; $display("FAIL pre_rst: level1 %0d vld %b expected 2 1", a_level[7:4], a_vld); end
        rst = 1'b1;
        #1;
        checks++; if (b_rdy !== 1'b0) begin errors++; $display("FAIL b_rdy_rst: got %b expected 0", b_rdy); end
        tick();
        rst = 1'b0;
        checks++; if (a_empty !== 4'hF) begin errors++; $display("FAIL rst2_empty: got %h expected f", a_empty); end
        checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL rst2_vld: got %b expected 0", a_vld); end
        checks++; if (a_drop !== 16'h0 || a_level !== 16'h0) begin errors++; $display("FAIL rst2_cnt: drop %h level %h expected 0 0", a_drop, a_level); end
    endtask

    task automatic test_latency();
        a_ack = 1'b1;
        write_a(2'd2, 16'hA5A5);
        checks++; if (a_vld !== 1'b0 || a_level[11:8] !== 4'd1) begin errors++; $display("FAIL lat_n: vld %b level2 %0d expected 0 1", a_vld, a_level[11:8]); end
        tick();
        checks++; if (a_vld !== 1'b1 || a_rxd !== 16'hA5A5 || a_rxch !== 2'd2) begin errors++; $display("FAIL lat_n1: vld %b rxd %h rxch %0d expected 1 a5a5 2", a_vld, a_rxd, a_rxch); end
        checks++; if (a_empty !== 4'hF) begin errors++; $display("FAIL lat_empty: got %h expected f", a_empty); end
        tick();
        checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL lat_drain: vld %b expected 0", a_vld); end
    endtask

    task automatic test_backpressure();
        a_ack = 1'b0;
        write_a(2'd3, 16'h0333);
        tick();
        checks++; if (a_vld !== 1'b1 || a_rxch !== 2'd3) begin errors++; $display("FAIL bp_hold: vld %b rxch %0d expected 1 3", a_vld, a_rxch); end
        for (int i = 0; i < 8; i++) write_a(2'd0, 16'h0100 + 16'(i));
        checks++; if (a_full[0] !== 1'b1 || a_level[3:0] !== 4'd8) begin errors++; $display("FAIL bp_full: full0 %b level0 %0d expected 1 8", a_full[0], a_level[3:0]); end
        a_txch = 2'd0; #1;
        checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy0: got %b expected 0", a_rdy); end
        a_txch = 2'd3; #1;
        checks++; if (a_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy3: got %b expected 1", a_rdy); end
        write_a(2'd0, 16'hDEAD);
        checks++; if (a_level[3:0] !== 4'd8) begin errors++; $display("FAIL bp_9th: level0 %0d expected 8", a_level[3:0]); end
        a_ack = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (a_vld !== 1'b1 || a_rxd !== 16'h0100 + 16'(i) || a_rxch !== 2'd0) begin errors++; $display("FAIL bp_drain%0d: vld %b rxd %h rxch %0d expected 1 %h 0", i, a_vld, a_rxd, a_rxch, 16'h0100 + 16'(i)); end
        end
        tick();
        checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL bp_end: vld %b expected 0", a_vld); end
        a_ack = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_d;
        do_reset();
        a_ack = 1'b0;
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 2; k++)
                write_a(2'(c), 16'h0A00 + 16'(c * 16 + k));
        a_ack = 1'b1;
        for (int j = 0; j < 8; j++) begin
            exp_d = 16'h0A00 + 16'((j % 4) * 16 + j / 4);
            checks++; if (a_vld !== 1'b1 || a_rxch !== 2'(j % 4) || a_rxd !== exp_d) begin errors++; $display("FAIL rr%0d: vld %b rxch %0d rxd %h expected 1 %0d %h", j, a_vld, a_rxch, a_rxd, j % 4, exp_d); end
            tick();
        end
        checks++; if (a_vld !== 1'b0) begin errors++; $display("FAIL rr_end: vld %b expected 0", a_vld); end
        a_ack = 1'b0;
    endtask

    task automatic test_output_hold();
        write_a(2'd1, 16'h5151);
        write_a(2'd1, 16'h5152);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (a_vld !== 1'b1 || a_rxd !== 16'h5151 || a_rxch !== 2'd1 || a_level[7:4] !== 4'd1) begin errors++; $display("FAIL hold%0d: vld %b rxd %h rxch %0d level1 %0d expected 1 5151 1 1", i, a_vld, a_rxd, a_rxch, a_level[7:4]); end
        end
        a_ack = 1'b1;
        tick();
        checks++; if (a_rxd !== 16'h5152 || a_level[7:4] !== 4'd0) begin errors++; $display("FAIL hold_next: rxd %h level1 %0d expected 5152 0", a_rxd, a_level[7:4]); end
        a_ack = 1'b0;
    endtask

    task automatic test_drop_mode();
        b_ack = 1'b0;
        // nine of ten fit: one moves to the output stage, eight fill the FIFO
        for (int i = 0; i < 10; i++) begin
            b_txch = 3'd1; b_txd = 16'h0600 + 16'(i); b_en = 1'b1;
            tick();
        end
        b_txch = 3'd5; b_txd = 16'hBAD0;
        tick();
        b_en = 1'b0;
        checks++; if (b_level[7:4] !== 4'd8 || b_full[1] !== 1'b1) begin errors++; $display("FAIL drop_level: level1 %0d full1 %b expected 8 1", b_level[7:4], b_full[1]); end
        checks++; if (b_drop !== 16'd2) begin errors++; $display("FAIL drop_cnt: got %0d expected 2", b_drop); end
        checks++; if (b_vld !== 1'b1 || b_rxd !== 16'h0600 || b_rdy !== 1'b1) begin errors++; $display("FAIL drop_out: vld %b rxd %h rdy %b expected 1 0600 1", b_vld, b_rxd, b_rdy); end
    endtask

    initial begin
        rst = 1'b1;
        a_txd = '0; a_txch = '0; a_en = 1'b0; a_ack = 1'b0;
        b_txd = '0; b_txch = '0; b_en = 1'b0; b_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        test_reset();
        test_latency();
        test_backpressure();
        test_round_robin();
        test_output_hold();
        test_drop_mode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
